// File: rtl/tcdm_bank_responder_if.sv
// Core-data request/response bus plus SRAM bank port of one TCDM bank responder.
// The slave modport is the responder's view; master is the requester/bank side.
interface tcdm_bank_responder_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 12,
    parameter int IdWidth   = 4
);
    localparam int ByteOffset = $clog2(DataWidth / 8);

    logic                          req_i;
    logic                          gnt_o;
    logic [AddrWidth-1:0]          addr_i;
    logic                          wen_i;
    logic [DataWidth/8-1:0]        be_i;
    logic [DataWidth-1:0]          wdata_i;
    logic [IdWidth-1:0]            id_i;

    logic                          resp_valid_o;
    logic                          resp_ready_i;
    logic [DataWidth-1:0]          resp_rdata_o;
    logic [IdWidth-1:0]            resp_id_o;
    logic                          resp_wen_o;

    logic                          mem_req_o;
    logic                          mem_we_o;
    logic [AddrWidth-ByteOffset-1:0] mem_addr_o;
    logic [DataWidth-1:0]          mem_wdata_o;
    logic [DataWidth-1:0]          mem_be_o;
    logic [DataWidth-1:0]          mem_rdata_i;

    modport slave (
        input  req_i, addr_i, wen_i, be_i, wdata_i, id_i, resp_ready_i, mem_rdata_i,
        output gnt_o, resp_valid_o, resp_rdata_o, resp_id_o, resp_wen_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output req_i, addr_i, wen_i, be_i, wdata_i, id_i, resp_ready_i, mem_rdata_i,
        input  gnt_o, resp_valid_o, resp_rdata_o, resp_id_o, resp_wen_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: grants core requests against a response credit counter,
// drives the SRAM, and returns one in-order tagged response per request.
module tcdm_bank_responder #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 12,
    parameter int IdWidth   = 4,
    parameter int RespDepth = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    tcdm_bank_responder_if.slave bus
);
    localparam int ByteOffset = $clog2(DataWidth / 8);
    localparam int NumBytes   = DataWidth / 8;
    localparam int CntW       = $clog2(RespDepth + 1);
    localparam int PtrW       = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   id;
        logic                 wen;
    } resp_t;

    logic [CntW-1:0]    cnt;
    logic [CntW-1:0]    fifo_cnt;
    logic [PtrW-1:0]    wptr;
    logic [PtrW-1:0]    rptr;
    logic               inflight;
    logic               inflight_wen;
    logic [IdWidth-1:0] inflight_id;
    resp_t              fifo_q [RespDepth];

    logic  grant;
    logic  fifo_empty;
    logic  resp_valid;
    logic  resp_hs;
    logic  push;
    logic  pop;
    resp_t cur;
    resp_t head;
    resp_t resp;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Credits cover in-flight plus buffered responses, so a grant never
    // outruns FIFO space; no path from resp_ready_i into the grant.
    assign grant     = bus.req_i & ~rst_i & (cnt < CntW'(RespDepth));
    assign bus.gnt_o = grant;

    assign bus.mem_req_o   = grant;
    assign bus.mem_we_o    = bus.wen_i;
    assign bus.mem_addr_o  = bus.addr_i[AddrWidth-1:ByteOffset];
    assign bus.mem_wdata_o = bus.wdata_i;

    for (genvar b = 0; b < NumBytes; b++) begin : g_be
        assign bus.mem_be_o[8*b +: 8] = {8{bus.be_i[b]}};
    end

    assign cur.rdata = inflight_wen ? '0 : bus.mem_rdata_i;
    assign cur.id    = inflight_id;
    assign cur.wen   = inflight_wen;

    assign fifo_empty = (fifo_cnt == '0);
    assign head       = fifo_q[rptr];
    assign resp       = fifo_empty ? cur : head;

    assign resp_valid = ~rst_i & (inflight | ~fifo_empty);
    assign resp_hs    = resp_valid & bus.resp_ready_i;
    // The SRAM word is only valid for one cycle: park it whenever it cannot
    // leave directly, and queue behind older buffered responses.
    assign push       = inflight & (~fifo_empty | ~bus.resp_ready_i);
    assign pop        = ~fifo_empty & bus.resp_ready_i;

    assign bus.resp_valid_o = resp_valid;
    assign bus.resp_rdata_o = resp.rdata;
    assign bus.resp_id_o    = resp.id;
    assign bus.resp_wen_o   = resp.wen;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt          <= '0;
            fifo_cnt     <= '0;
            wptr         <= '0;
            rptr         <= '0;
            inflight     <= 1'b0;
            inflight_id  <= '0;
            inflight_wen <= 1'b0;
        end else begin
            inflight <= grant;
            if (grant) begin
                inflight_id  <= bus.id_i;
                inflight_wen <= bus.wen_i;
            end
            case ({grant, resp_hs})
                2'b10:   cnt <= cnt + CntW'(1);
                2'b01:   cnt <= cnt - CntW'(1);
                default: cnt <= cnt;
            endcase
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CntW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CntW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push) wptr <= ptr_next(wptr);
            if (pop)  rptr <= ptr_next(rptr);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr] <= cur;
    end
endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed plus random bench for tcdm_bank_responder with an SRAM model,
// a reference memory and an in-order response scoreboard.
module tb_tcdm_bank_responder;
    localparam int Words = 1024;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  id;
        logic        wen;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tcdm_bank_responder_if #(.DataWidth(32), .AddrWidth(12), .IdWidth(4)) bus ();

    tcdm_bank_responder #(.DataWidth(32), .AddrWidth(12), .IdWidth(4), .RespDepth(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h10) return 32'hDEADBEEF;
        if (i == 32'h11) return 32'hAAAAAAAA;
        return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    // SRAM bank model: 1-cycle read latency, bit-level write mask.
    logic [31:0] sram [Words];
    logic [31:0] sram_rdata;
    assign bus.mem_rdata_i = sram_rdata;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Words; i++) sram[i] <= init_word(i);
        end else if (bus.mem_req_o) begin
            if (bus.mem_we_o)
                sram[bus.mem_addr_o] <= (sram[bus.mem_addr_o] & ~bus.mem_be_o) |
                                        (bus.mem_wdata_o & bus.mem_be_o);
            else
                sram_rdata <= sram[bus.mem_addr_o];
        end
    end

    logic [31:0] ref_mem [Words];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_stall = 1'b0;
    exp_t        prev_resp;
    int          ngr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Runs at the falling edge: retire responses against the scoreboard, then
    // record any grant happening this cycle.
    task automatic monitor();
        exp_t e;
        logic [9:0] wa;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
            for (int i = 0; i < Words; i++) ref_mem[i] = init_word(i);
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.resp_valid_o), 32'd1);
                chk("stall_rdata", bus.resp_rdata_o, prev_resp.rdata);
                chk("stall_id",    32'(bus.resp_id_o), 32'(prev_resp.id));
                chk("stall_wen",   32'(bus.resp_wen_o), 32'(prev_resp.wen));
            end
            if (bus.resp_valid_o && bus.resp_ready_i) begin
                chk("sb_underflow", 32'(sb.size() == 0), 32'd0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_rdata", bus.resp_rdata_o, e.rdata);
                    chk("sb_id",    32'(bus.resp_id_o), 32'(e.id));
                    chk("sb_wen",   32'(bus.resp_wen_o), 32'(e.wen));
                end
            end
            prev_stall     = bus.resp_valid_o & ~bus.resp_ready_i;
            prev_resp.rdata = bus.resp_rdata_o;
            prev_resp.id    = bus.resp_id_o;
            prev_resp.wen   = bus.resp_wen_o;
            if (bus.req_i && bus.gnt_o) begin
                wa = bus.addr_i[11:2];
                e.id  = bus.id_i;
                e.wen = bus.wen_i;
                e.rdata = bus.wen_i ? 32'h0 : ref_mem[wa];
                sb.push_back(e);
                if (bus.wen_i)
                    for (int b = 0; b < 4; b++)
                        if (bus.be_i[b]) ref_mem[wa][8*b +: 8] = bus.wdata_i[8*b +: 8];
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r, input logic w, input logic [11:0] a,
                           input logic [3:0] be, input logic [31:0] d, input logic [3:0] id);
        bus.req_i = r; bus.wen_i = w; bus.addr_i = a;
        bus.be_i = be; bus.wdata_i = d; bus.id_i = id;
    endtask

    initial begin
        set_req(1'b0, 1'b0, 12'h0, 4'hF, 32'h0, 4'h0);
        bus.resp_ready_i = 1'b1;
        rst = 1'b1;
        adv();
        // Request held during reset must not be granted.
        bus.req_i = 1'b1;
        sample();
        chk("rst_gnt",   32'(bus.gnt_o), 32'd0);
        chk("rst_memreq", 32'(bus.mem_req_o), 32'd0);
        chk("rst_valid", 32'(bus.resp_valid_o), 32'd0);
        adv();
        rst = 1'b0;
        bus.req_i = 1'b0;
        sample();
        chk("rel_cnt",   32'(dut.cnt), 32'd0);
        chk("rel_valid", 32'(bus.resp_valid_o), 32'd0);
        adv();

        // Single read.
        set_req(1'b1, 1'b0, 12'h040, 4'hF, 32'h0, 4'd3);
        sample();
        chk("rd_gnt",     32'(bus.gnt_o), 32'd1);
        chk("rd_memreq",  32'(bus.mem_req_o), 32'd1);
        chk("rd_memaddr", 32'(bus.mem_addr_o), 32'h10);
        chk("rd_memwe",   32'(bus.mem_we_o), 32'd0);
        adv();
        bus.req_i = 1'b0;
        sample();
        chk("rd_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("rd_rdata", bus.resp_rdata_o, 32'hDEADBEEF);
        chk("rd_id",    32'(bus.resp_id_o), 32'd3);
        chk("rd_wen",   32'(bus.resp_wen_o), 32'd0);
        adv();

        // Partial write followed by read-back.
        set_req(1'b1, 1'b1, 12'h044, 4'b0101, 32'h11223344, 4'd5);
        sample();
        chk("wr_gnt",    32'(bus.gnt_o), 32'd1);
        chk("wr_membe",  bus.mem_be_o, 32'h00FF00FF);
        chk("wr_wdata",  bus.mem_wdata_o, 32'h11223344);
        chk("wr_memwe",  32'(bus.mem_we_o), 32'd1);
        chk("wr_addr",   32'(bus.mem_addr_o), 32'h11);
        adv();
        set_req(1'b1, 1'b0, 12'h044, 4'hF, 32'h0, 4'd6);
        sample();
        chk("wack_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("wack_wen",   32'(bus.resp_wen_o), 32'd1);
        chk("wack_rdata", bus.resp_rdata_o, 32'h0);
        chk("wack_id",    32'(bus.resp_id_o), 32'd5);
        adv();
        bus.req_i = 1'b0;
        sample();
        chk("rb_rdata", bus.resp_rdata_o, 32'hAA22AA44);
        chk("rb_id",    32'(bus.resp_id_o), 32'd6);
        adv();

        // Streaming: eight back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, 1'b0, 12'(12'h100 + i * 4), 4'hF, 32'h0, 4'(i));
            sample();
            chk("st_gnt", 32'(bus.gnt_o), 32'd1);
            if (i > 0) begin
                chk("st_valid", 32'(bus.resp_valid_o), 32'd1);
                chk("st_id",    32'(bus.resp_id_o), 32'(i - 1));
            end
            adv();
        end
        bus.req_i = 1'b0;
        sample();
        chk("st_last_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("st_last_id",    32'(bus.resp_id_o), 32'd7);
        adv();
        sample();
        chk("st_idle", 32'(bus.resp_valid_o), 32'd0);
        adv();

        // Backpressure: only two credits available.
        bus.resp_ready_i = 1'b0;
        ngr = 0;
        for (int k = 0; k < 5; k++) begin
            set_req(1'b1, 1'b0, 12'(12'h200 + ngr * 4), 4'hF, 32'h0, 4'(8 + ngr));
            sample();
            if (bus.gnt_o) ngr++;
            adv();
        end
        sample();
        chk("bp_grants", 32'(ngr), 32'd2);
        chk("bp_gnt",    32'(bus.gnt_o), 32'd0);
        chk("bp_cnt",    32'(dut.cnt), 32'd2);
        chk("bp_valid",  32'(bus.resp_valid_o), 32'd1);
        chk("bp_id",     32'(bus.resp_id_o), 32'd8);
        adv();
        bus.resp_ready_i = 1'b1;
        bus.req_i = 1'b0;
        sample();
        chk("dr0_id", 32'(bus.resp_id_o), 32'd8);
        adv();
        sample();
        chk("dr1_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("dr1_id",    32'(bus.resp_id_o), 32'd9);
        adv();
        set_req(1'b1, 1'b0, 12'h208, 4'hF, 32'h0, 4'hC);
        sample();
        chk("dr_done_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("dr_done_cnt",   32'(dut.cnt), 32'd0);
        chk("resume_gnt",    32'(bus.gnt_o), 32'd1);
        adv();
        bus.req_i = 1'b0;
        sample();
        chk("resume_id", 32'(bus.resp_id_o), 32'hC);
        adv();

        // Grant and retire in the same cycle at cnt=1.
        set_req(1'b1, 1'b0, 12'h300, 4'hF, 32'h0, 4'hA);
        sample();
        adv();
        set_req(1'b1, 1'b0, 12'h304, 4'hF, 32'h0, 4'hB);
        sample();
        chk("sim_cnt_pre", 32'(dut.cnt), 32'd1);
        chk("sim_gnt",     32'(bus.gnt_o), 32'd1);
        chk("sim_id_a",    32'(bus.resp_id_o), 32'hA);
        adv();
        bus.req_i = 1'b0;
        sample();
        chk("sim_cnt_post", 32'(dut.cnt), 32'd1);
        chk("sim_id_b",     32'(bus.resp_id_o), 32'hB);
        adv();
        sample();
        chk("sim_cnt_end", 32'(dut.cnt), 32'd0);
        adv();

        // Reset with two responses outstanding.
        bus.resp_ready_i = 1'b0;
        set_req(1'b1, 1'b0, 12'h040, 4'hF, 32'h0, 4'd1);
        sample();
        adv();
        bus.id_i = 4'd2;
        sample();
        adv();
        bus.req_i = 1'b0;
        sample();
        chk("mr_cnt_pre", 32'(dut.cnt), 32'd2);
        adv();
        rst = 1'b1;
        sample();
        chk("mr_valid_rst", 32'(bus.resp_valid_o), 32'd0);
        adv();
        rst = 1'b0;
        bus.resp_ready_i = 1'b1;
        set_req(1'b1, 1'b0, 12'h040, 4'hF, 32'h0, 4'd9);
        sample();
        chk("mr_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("mr_cnt",   32'(dut.cnt), 32'd0);
        chk("mr_gnt",   32'(bus.gnt_o), 32'd1);
        adv();
        bus.req_i = 1'b0;
        sample();
        chk("mr_rd_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("mr_rd_rdata", bus.resp_rdata_o, 32'hDEADBEEF);
        chk("mr_rd_id",    32'(bus.resp_id_o), 32'd9);
        adv();

        // Random mix of reads, writes and backpressure.
        for (int k = 0; k < 200; k++) begin
            set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    12'($urandom_range(0, 15) * 4 + 12'h400), 4'($urandom),
                    $urandom, 4'($urandom));
            bus.resp_ready_i = ($urandom_range(0, 3) != 0);
            sample();
            adv();
        end
        bus.req_i = 1'b0;
        bus.resp_ready_i = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            sample();
            adv();
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
- Responder end of the tile's core-data request interface (req/gnt out, vld/rdata back), placed in front of one TCDM SRAM bank.
- Accepts granted requests, drives the bank, and returns exactly one response per request (read or write), tagged with the requester ID.
- Response port is valid/ready with credit-based buffering, so the bank never drops read data under backpressure.

Parameters:
- DataWidth, 32, data word width in bits; multiple of 8.
- AddrWidth, 12, byte-address width of the bank; word address is AddrWidth-ByteOffset bits, ByteOffset = $clog2(DataWidth/8).
- IdWidth, 4, width of the requester tag returned with each response.
- RespDepth, 2, maximum outstanding responses (in-flight plus buffered); >=1; 2 is required for one-per-cycle throughput.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  request valid
- gnt_o  out  1  request granted; handshake = req_i & gnt_o
- addr_i  in  AddrWidth  byte address; low ByteOffset bits ignored
- wen_i  in  1  1 = write, 0 = read
- be_i  in  DataWidth/8  byte enables (writes only)
- wdata_i  in  DataWidth  write data
- id_i  in  IdWidth  requester tag
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response accepted
- resp_rdata_o  out  DataWidth  read data; 0 for write responses
- resp_id_o  out  IdWidth  tag of the request
- resp_wen_o  out  1  1 = write acknowledge
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  AddrWidth-ByteOffset  SRAM word address
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_be_o  out  DataWidth  bit-level enable; each byte enable replicated 8 times
- mem_rdata_i  in  DataWidth  SRAM read data, valid exactly 1 cycle after mem_req_o

Behaviour:
- Clock and reset: one clock, clk_i, all state on its rising edge. rst_i is synchronous and active-high.
- Reset: credit counter = 0, in-flight flag = 0, FIFO empty. gnt_o = 0, mem_req_o = 0 and resp_valid_o = 0 while rst_i is high. On the first cycle after release, gnt_o follows the rule below.
- Credit counter cnt (0..RespDepth):
  - gnt_o = req_i & (cnt < RespDepth). gnt_o has no combinational path from resp_ready_i.
  - Grant only: cnt+1. Response handshake only: cnt-1. Both in the same cycle: unchanged. cnt never exceeds RespDepth and never underflows.
- SRAM drive:
  - mem_req_o = req_i & gnt_o, in the same cycle as the grant.
  - mem_we_o = wen_i.
  - mem_addr_o = addr_i[AddrWidth-1:ByteOffset].
  - mem_wdata_o = wdata_i; mem_be_o = bit-expanded be_i.
  - While mem_req_o is low, the values on the other mem_* outputs are don't-care.
- In-flight stage: on a grant, register {inflight=1, id_i, wen_i}; otherwise inflight <= 0.
- Response path, cycle t+1 after a grant at cycle t:
  - FIFO empty: bypass. resp_valid_o=1, resp_rdata_o = wen ? 0 : mem_rdata_i, with the registered id/wen. If resp_ready_i is low, push {rdata, id, wen} into the FIFO.
  - FIFO non-empty: push the in-flight result. The output shows the FIFO head; pop on resp_valid_o & resp_ready_i.
  - Push and pop in the same cycle are legal.
- FIFO: RespDepth entries. The credit rule guarantees a push never overflows it.
- Ordering: responses are returned strictly in grant order.
- Read latency: 1 cycle from grant to resp_valid_o when unstalled. Write acks have the same latency.
- Back-to-back: with RespDepth=2 and resp_ready_i held high, one grant and one response per cycle.
- Data stability: while resp_valid_o=1 and resp_ready_i=0, resp_rdata_o, resp_id_o and resp_wen_o hold stable.
- Reset mid-operation: in-flight and buffered responses are discarded. The requester side must be reset in the same cycle.

Test Plan:
- Single read: preload word 0x010 = 0xDEADBEEF; issue req addr 0x040, id 3 at cycle 5 -> gnt_o=1 at cycle 5; resp_valid_o=1 at cycle 6 with rdata 0xDEADBEEF, id 3, resp_wen_o=0.
- Partial write, then read: write 0x11223344 to 0x044 with be=4'b0101, then read it (bank previously 0xAAAAAAAA) -> write ack has rdata 0 and resp_wen_o=1; read returns 0xAA22AA44; mem_be_o during the write = 0x00FF00FF.
- Streaming: 8 reads, ids 0..7, resp_ready_i=1 -> gnt_o high for 8 consecutive cycles; responses in 8 consecutive cycles, ids 0..7 in order.
- Backpressure: resp_ready_i=0, req_i held high -> exactly 2 grants, then gnt_o=0 and cnt=2. Raise ready -> both responses drain in order with data unchanged, then grants resume.
- Simultaneous grant and retire: at cnt=1, a grant and a response handshake in the same cycle -> cnt stays 1; no lost or duplicated response.
- Reset mid-stream: assert rst_i for 1 cycle with 2 responses outstanding -> next cycle resp_valid_o=0 and cnt=0; a new read then completes with 1-cycle latency.
